vector_ls_strided: RTL and testbench

//  Generalised vector load/store sequencer between the vector unit slices and one OCP-style bus master port.

---
 rtl/vector_ls_strided.sv | 205 ++++++++++++++++++++
 tb/tb_vector_ls_strided.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_ls_strided.sv
// Strided vector load/store sequencer between the vector slices and one OCP-style master port.
// Keeps up to MAX_OUTSTANDING requests in flight; an error response stops issue and drains.
//
// state  | meaning
// IDLE   | waiting for new_op
// ACTIVE | issuing commands and collecting responses
// DRAIN  | error seen; no new commands, collecting the in-flight responses
module vector_ls_strided #(
   parameter int NUM_SLICES      = 1,
   parameter int NUM_ELEMS       = 8,
   parameter int ELEM_SIZE       = 16,
   parameter int SCALAR_SIZE     = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STRIDE_WIDTH    = 16,
   localparam int SPV = NUM_ELEMS * ELEM_SIZE / SCALAR_SIZE,
   localparam int CW  = $clog2(SPV * NUM_SLICES) + 1,
   localparam int SW  = (SPV > 1) ? $clog2(SPV) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           new_op,
   input  logic                           op_we,
   input  logic [31:0]                    op_base,
   input  logic signed [STRIDE_WIDTH-1:0] op_stride,
   input  logic [CW-1:0]                  op_count,
   output logic                           busy,
   output logic                           complete,
   output logic                           error,
   output logic [SW-1:0]                  sel_store_word,
   output logic [NUM_SLICES-1:0]          serial_output,
   input  logic [SCALAR_SIZE-1:0]         store_serial_in,
   output logic [SW-1:0]                  sel_word,
   output logic [NUM_SLICES-1:0]          load_en,
   output logic [SCALAR_SIZE-1:0]         load_out,
   output logic                           bus_mreset_n,
   output logic [2:0]                     bus_mcmd,
   output logic [31:0]                    bus_maddr,
   output logic [SCALAR_SIZE-1:0]         bus_mdata,
   output logic [SCALAR_SIZE/8-1:0]       bus_mbyteen,
   input  logic                           bus_scmdaccept,
   input  logic [1:0]                     bus_sresp,
   input  logic [SCALAR_SIZE-1:0]         bus_sdata,
   output logic                           bus_mrespaccept
);

   localparam int OW      = $clog2(MAX_OUTSTANDING + 1);
   localparam int SPV_LOG = $clog2(SPV);

   localparam logic [2:0] CMD_IDLE  = 3'd0;
   localparam logic [2:0] CMD_WR    = 3'd1;
   localparam logic [2:0] CMD_RD    = 3'd2;
   localparam logic [1:0] RESP_NULL = 2'd0;
   localparam logic [1:0] RESP_DVA  = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t                         state_q, state_d;
   logic                           we_q, we_d;
   logic [31:0]                    addr_q, addr_d;
   logic signed [STRIDE_WIDTH-1:0] stride_q, stride_d;
   logic [CW-1:0]                  count_q, count_d;
   logic [CW-1:0]                  req_q, req_d;
   logic [CW-1:0]                  resp_q, resp_d;
   logic [OW-1:0]                  outst_q, outst_d;
   logic                           error_q, error_d;
   logic                           complete_q, complete_d;

   logic issue;
   logic cmd_acc;
   logic resp_take;
   logic resp_vld;
   logic resp_ok;
   logic resp_bad;

   always_comb begin
      issue     = (state_q == ST_ACTIVE) && (req_q != count_q) &&
                  (outst_q < OW'(MAX_OUTSTANDING));
      cmd_acc   = issue && bus_scmdaccept;
      resp_take = (state_q != ST_IDLE) && (outst_q != '0);
      resp_vld  = resp_take && (bus_sresp != RESP_NULL);
      resp_ok   = resp_vld && (bus_sresp == RESP_DVA);
      resp_bad  = resp_vld && bus_sresp[1];
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      stride_d   = stride_q;
      count_d    = count_q;
      req_d      = req_q;
      resp_d     = resp_q;
      outst_d    = outst_q;
      error_d    = error_q;
      complete_d = 1'b0;

      if (cmd_acc) begin
         req_d  = req_q + CW'(1);
         addr_d = addr_q + 32'(stride_q);
      end
      if (resp_vld) begin
         resp_d = resp_q + CW'(1);
      end
      // a command accept and a response in the same cycle cancel out
      if (cmd_acc && !resp_vld) begin
         outst_d = outst_q + OW'(1);
      end else if (!cmd_acc && resp_vld) begin
         outst_d = outst_q - OW'(1);
      end
      if (resp_bad) begin
         error_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (new_op) begin
               we_d     = op_we;
               addr_d   = op_base >> 2;
               stride_d = op_stride;
               count_d  = op_count;
               req_d    = '0;
               resp_d   = '0;
               outst_d  = '0;
               error_d  = 1'b0;
               if (op_count == '0) begin
                  complete_d = 1'b1;
               end else begin
                  state_d = ST_ACTIVE;
               end
            end
         end
         ST_ACTIVE: begin
            if (resp_bad) begin
               if (outst_d == '0) begin
                  state_d    = ST_IDLE;
                  complete_d = 1'b1;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else if (resp_ok && (resp_d == count_q)) begin
               state_d    = ST_IDLE;
               complete_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (outst_d == '0) begin
               state_d    = ST_IDLE;
               complete_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         stride_q   <= '0;
         count_q    <= '0;
         req_q      <= '0;
         resp_q     <= '0;
         outst_q    <= '0;
         error_q    <= 1'b0;
         complete_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         stride_q   <= stride_d;
         count_q    <= count_d;
         req_q      <= req_d;
         resp_q     <= resp_d;
         outst_q    <= outst_d;
         error_q    <= error_d;
         complete_q <= complete_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign complete = complete_q;
   assign error    = error_q;

   assign bus_mreset_n    = ~reset;
   assign bus_mcmd        = issue ? (we_q ? CMD_WR : CMD_RD) : CMD_IDLE;
   assign bus_maddr       = addr_q;
   assign bus_mdata       = store_serial_in;
   assign bus_mbyteen     = '1;
   assign bus_mrespaccept = resp_take;

   // scalar index splits into slice (upper bits) and word within the vector (lower bits)
   assign serial_output  = issue ? (NUM_SLICES'(1) << (req_q >> SPV_LOG)) : '0;
   assign sel_store_word = issue ? SW'(req_q & CW'(SPV - 1)) : '0;
   assign load_en        = (resp_ok && !we_q) ? (NUM_SLICES'(1) << (resp_q >> SPV_LOG)) : '0;
   assign sel_word       = (resp_ok && !we_q) ? SW'(resp_q & CW'(SPV - 1)) : '0;
   assign load_out       = bus_sdata;

endmodule

// File: tb/tb_vector_ls_strided.sv
// Directed bench for vector_ls_strided with a latency-programmable slave and
// a slice register model feeding store data.
module tb_vector_ls_strided;
   localparam int NS = 2;
   localparam int CW = 4;
   localparam int SW = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           new_op;
   logic           op_we;
   logic [31:0]    op_base;
   logic [15:0]    op_stride;
   logic [CW-1:0]  op_count;
   logic           busy;
   logic           complete;
   logic           error;
   logic [SW-1:0]  sel_store_word;
   logic [NS-1:0]  serial_output;
   logic [31:0]    store_serial_in;
   logic [SW-1:0]  sel_word;
   logic [NS-1:0]  load_en;
   logic [31:0]    load_out;
   logic           bus_mreset_n;
   logic [2:0]     bus_mcmd;
   logic [31:0]    bus_maddr;
   logic [31:0]    bus_mdata;
   logic [3:0]     bus_mbyteen;
   logic           bus_scmdaccept;
   logic [1:0]     bus_sresp;
   logic [31:0]    bus_sdata;
   logic           bus_mrespaccept;

   vector_ls_strided #(.NUM_SLICES(NS)) dut (
      .clk(clk), .reset(reset), .new_op(new_op), .op_we(op_we), .op_base(op_base),
      .op_stride(op_stride), .op_count(op_count), .busy(busy), .complete(complete),
      .error(error), .sel_store_word(sel_store_word), .serial_output(serial_output),
      .store_serial_in(store_serial_in), .sel_word(sel_word), .load_en(load_en),
      .load_out(load_out), .bus_mreset_n(bus_mreset_n), .bus_mcmd(bus_mcmd),
      .bus_maddr(bus_maddr), .bus_mdata(bus_mdata), .bus_mbyteen(bus_mbyteen),
      .bus_scmdaccept(bus_scmdaccept), .bus_sresp(bus_sresp), .bus_sdata(bus_sdata),
      .bus_mrespaccept(bus_mrespaccept)
   );

   always #5 clk = ~clk;

   // slice register model: word value encodes selected slice and word index
   assign store_serial_in = 32'h5A00_0000 | (32'(serial_output) << 8) | 32'(sel_store_word);

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   int cyc = 0, op_cyc = 0, lat = 1, err_at = 0, resp_num = 0;
   int complete_cnt = 0, complete_cyc = -1, last_resp_cyc = -1, max_outst = 0;
   bit acc_en = 1'b1;

   int          pend_due[$];
   logic [31:0] pend_addr[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   logic [2:0]  log_cmd[$];
   int          acc_cyc[$];
   logic [NS-1:0] log_le[$];
   logic [SW-1:0] log_sw[$];
   logic [31:0] log_lo[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one bus cycle: slave drives at negedge, transfers are recorded just after
   task automatic tick();
      @(negedge clk);
      bus_scmdaccept = acc_en;
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
         bus_sresp = (resp_num + 1 == err_at) ? 2'd3 : 2'd1;
         bus_sdata = 32'hD000_0000 ^ pend_addr[0];
      end else begin
         bus_sresp = 2'd0;
         bus_sdata = 32'h0;
      end
      #1;
      if (bus_mrespaccept && bus_sresp != 2'd0) begin
         resp_num++;
         last_resp_cyc = cyc;
         if (load_en != '0) begin
            log_le.push_back(load_en);
            log_sw.push_back(sel_word);
            log_lo.push_back(load_out);
         end
         void'(pend_due.pop_front());
         void'(pend_addr.pop_front());
      end
      if (bus_mcmd != 3'd0 && bus_scmdaccept) begin
         log_addr.push_back(bus_maddr);
         log_data.push_back(bus_mdata);
         log_cmd.push_back(bus_mcmd);
         acc_cyc.push_back(cyc);
         pend_due.push_back(cyc + lat);
         pend_addr.push_back(bus_maddr);
      end
      if (pend_due.size() > max_outst) max_outst = pend_due.size();
      if (complete) begin
         complete_cnt++;
         complete_cyc = cyc;
      end
      cyc++;
   endtask

   task automatic start_op(input logic we, input logic [31:0] base, input logic [15:0] stride,
                           input logic [CW-1:0] cnt);
      log_addr.delete(); log_data.delete(); log_cmd.delete(); acc_cyc.delete();
      log_le.delete(); log_sw.delete(); log_lo.delete();
      resp_num = 0; complete_cnt = 0; complete_cyc = -1; max_outst = 0;
      op_we = we; op_base = base; op_stride = stride; op_count = cnt;
      new_op = 1'b1;
      op_cyc = cyc;
      tick();
      new_op = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (complete_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done"}, 64'(complete_cnt), 64'd1);
      tick();
      check({tag, "_pulse"}, 64'(complete), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b1; new_op = 1'b0; op_we = 1'b0; op_base = '0; op_stride = '0; op_count = '0;
      bus_scmdaccept = 1'b0; bus_sresp = 2'd0; bus_sdata = '0;
      #2;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_complete", 64'(complete), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_mcmd", 64'(bus_mcmd), 64'd0);
      check("rst_mreset_n", 64'(bus_mreset_n), 64'd0);
      check("rst_respacc", 64'(bus_mrespaccept), 64'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rel_mreset_n", 64'(bus_mreset_n), 64'd1);
      check("rel_byteen", 64'(bus_mbyteen), 64'hF);

      // 1: back-to-back load, one-cycle slave
      lat = 1;
      start_op(1'b0, 32'h100, 16'd1, 4'd8);
      wait_done(40, "t1");
      check("t1_ncmd", 64'(log_addr.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         check("t1_addr", 64'(log_addr[i]), 64'(32'h40 + i));
         check("t1_cyc", 64'(acc_cyc[i]), 64'(op_cyc + i));
         check("t1_cmd", 64'(log_cmd[i]), 64'd2);
      end
      check("t1_nload", 64'(log_le.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         check("t1_load_en", 64'(log_le[i]), 64'(1 << (i / 4)));
         check("t1_sel_word", 64'(log_sw[i]), 64'(i % 4));
         check("t1_load_out", 64'(log_lo[i]), 64'(32'hD000_0000 ^ (32'h40 + i)));
      end
      check("t1_cpl_after_last", 64'(complete_cyc), 64'(last_resp_cyc + 1));
      check("t1_cpl_cyc", 64'(complete_cyc), 64'(op_cyc + 9));
      check("t1_error", 64'(error), 64'd0);

      // 2: store with negative stride
      start_op(1'b1, 32'h200, 16'hFFFE, 4'd4);
      wait_done(40, "t2");
      check("t2_ncmd", 64'(log_addr.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check("t2_addr", 64'(log_addr[i]), 64'(32'h80 - 2 * i));
         check("t2_cmd", 64'(log_cmd[i]), 64'd1);
         check("t2_data", 64'(log_data[i]), 64'(32'h5A00_0100 | i));
      end
      check("t2_noload", 64'(log_le.size()), 64'd0);
      check("t2_cpl_cyc", 64'(complete_cyc), 64'(op_cyc + 5));

      // 3: latency 10 store across both slices, outstanding limit
      lat = 10;
      start_op(1'b1, 32'h0, 16'd3, 4'd8);
      wait_done(60, "t3");
      check("t3_max_outst", 64'(max_outst), 64'd4);
      check("t3_acc3", 64'(acc_cyc[3]), 64'(op_cyc + 3));
      check("t3_acc4", 64'(acc_cyc[4]), 64'(op_cyc + 11));
      check("t3_acc7", 64'(acc_cyc[7]), 64'(op_cyc + 14));
      for (int i = 0; i < 8; i++) begin
         check("t3_addr", 64'(log_addr[i]), 64'(3 * i));
         check("t3_data", 64'(log_data[i]), 64'(32'h5A00_0000 | ((1 << (i / 4)) << 8) | (i % 4)));
      end
      check("t3_cpl_cyc", 64'(complete_cyc), 64'(op_cyc + 25));

      // 4: ERR on third response with four in flight
      lat = 4; err_at = 3;
      start_op(1'b0, 32'h1000, 16'd1, 4'd8);
      wait_done(60, "t4");
      err_at = 0;
      check("t4_ncmd", 64'(log_addr.size()), 64'd6);
      check("t4_last_acc", 64'(acc_cyc[5]), 64'(op_cyc + 6));
      check("t4_max_outst", 64'(max_outst), 64'd4);
      check("t4_drained", 64'(resp_num), 64'd6);
      check("t4_cpl_cyc", 64'(complete_cyc), 64'(op_cyc + 11));
      check("t4_error", 64'(error), 64'd1);

      // 5: zero-count op clears error; new_op while busy is ignored
      lat = 1;
      start_op(1'b0, 32'h40, 16'd1, 4'd0);
      check("t5_cpl", 64'(complete_cnt), 64'd1);
      check("t5_cpl_cyc", 64'(complete_cyc), 64'(op_cyc));
      check("t5_err_clr", 64'(error), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_nocmd", 64'(log_addr.size()), 64'd0);
      tick();
      check("t5_pulse", 64'(complete), 64'd0);

      lat = 10;
      start_op(1'b0, 32'h400, 16'd1, 4'd3);
      tick();
      op_we = 1'b1; op_base = 32'h800; op_stride = 16'd5; op_count = 4'd2; new_op = 1'b1;
      tick();
      new_op = 1'b0;
      wait_done(60, "t5b");
      check("t5b_ncmd", 64'(log_addr.size()), 64'd3);
      check("t5b_addr2", 64'(log_addr[2]), 64'h102);
      check("t5b_cmd2", 64'(log_cmd[2]), 64'd2);
      check("t5b_nload", 64'(log_le.size()), 64'd3);

      // 6: reset mid-load with two outstanding
      start_op(1'b0, 32'h2000, 16'd1, 4'd8);
      tick();
      check("t6_outst", 64'(pend_due.size()), 64'd2);
      reset = 1'b1;
      #1;
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_mcmd", 64'(bus_mcmd), 64'd0);
      check("t6_mreset_n", 64'(bus_mreset_n), 64'd0);
      check("t6_respacc", 64'(bus_mrespaccept), 64'd0);
      pend_due.delete(); pend_addr.delete();
      tick();
      reset = 1'b0;
      lat = 1;
      tick();
      start_op(1'b0, 32'h300, 16'd1, 4'd2);
      wait_done(40, "t6b");
      check("t6b_ncmd", 64'(log_addr.size()), 64'd2);
      check("t6b_addr0", 64'(log_addr[0]), 64'hC0);
      check("t6b_addr1", 64'(log_addr[1]), 64'hC1);
      check("t6b_le0", 64'(log_le[0]), 64'd1);
      check("t6b_sw0", 64'(log_sw[0]), 64'd0);
      check("t6b_sw1", 64'(log_sw[1]), 64'd1);
      check("t6b_cpl_cyc", 64'(complete_cyc), 64'(op_cyc + 3));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
